// File: rtl/exu_commit_mc_if.sv
// Commit-channel and IFU redirect bundle for exu_commit_mc.
// Channel k's payload sits at bits [k*W +: W] of each packed vector.
interface exu_commit_mc_if #(
  parameter int NCH  = 2,
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic [NCH-1:0]      cmt_i_valid;
  logic [NCH-1:0]      cmt_i_ready;
  logic [NCH*PC_W-1:0] cmt_i_pc;
  logic [NCH*XLEN-1:0] cmt_i_imm;
  logic [NCH-1:0]      cmt_i_bjp;
  logic [NCH-1:0]      cmt_i_bjp_taken;
  logic [NCH-1:0]      cmt_i_bjp_prdt;
  logic [NCH-1:0]      cmt_i_ebreak;
  logic [NCH*XLEN-1:0] cmt_i_a0;
  logic                flush_req;
  logic                flush_ack;
  logic [PC_W-1:0]     flush_pc;

  modport master (
    output cmt_i_valid, cmt_i_pc, cmt_i_imm, cmt_i_bjp, cmt_i_bjp_taken,
           cmt_i_bjp_prdt, cmt_i_ebreak, cmt_i_a0, flush_ack,
    input  cmt_i_ready, flush_req, flush_pc
  );

  modport slave (
    input  cmt_i_valid, cmt_i_pc, cmt_i_imm, cmt_i_bjp, cmt_i_bjp_taken,
           cmt_i_bjp_prdt, cmt_i_ebreak, cmt_i_a0, flush_ack,
    output cmt_i_ready, flush_req, flush_pc
  );
endinterface

// File: rtl/exu_commit_mc.sv
// Fixed-priority multi-channel commit stage: one retire per cycle, mispredict
// redirect handshake toward IFU, sticky ebreak trap and a retire counter.
//
// state | meaning
// RUN   | granting the lowest-index valid channel each cycle
// FLUSH | redirect pending; all channels blocked until flush_ack
// TRAP  | ebreak retired; everything frozen until rst
module exu_commit_mc #(
  parameter int NCH   = 2,
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  exu_commit_mc_if.slave     cmt,
  output logic               commit_trap,
  output logic [XLEN-1:0]    cmt_cause,
  output logic [XLEN-1:0]    endcode,
  output logic [CNT_W-1:0]   retire_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  state_t          state;
  logic            flush_req;
  logic [PC_W-1:0] flush_pc;

  logic [NCH-1:0]  ready;
  logic            fire;
  int              gsel;
  logic [PC_W-1:0] g_pc;
  logic [PC_W-1:0] g_imm;
  logic [XLEN-1:0] g_a0;
  logic            g_bjp;
  logic            g_taken;
  logic            g_prdt;
  logic            g_ebreak;
  logic            g_mis;
  logic [PC_W-1:0] g_target;

  // Scan from the top so the lowest valid index wins.
  always_comb begin
    ready = '0;
    fire  = 1'b0;
    gsel  = 0;
    if (state == S_RUN) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (cmt.cmt_i_valid[k]) begin
          gsel = k;
          fire = 1'b1;
        end
      end
      if (fire) ready[gsel] = 1'b1;
    end
  end

  always_comb begin
    g_pc     = cmt.cmt_i_pc[gsel*PC_W +: PC_W];
    g_imm    = PC_W'(cmt.cmt_i_imm[gsel*XLEN +: XLEN]);
    g_a0     = cmt.cmt_i_a0[gsel*XLEN +: XLEN];
    g_bjp    = cmt.cmt_i_bjp[gsel];
    g_taken  = cmt.cmt_i_bjp_taken[gsel];
    g_prdt   = cmt.cmt_i_bjp_prdt[gsel];
    g_ebreak = cmt.cmt_i_ebreak[gsel];
    g_mis    = g_bjp & (g_taken ^ g_prdt);
    g_target = g_taken ? (g_pc + g_imm) : (g_pc + PC_W'(4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      flush_req   <= 1'b0;
      flush_pc    <= '0;
      commit_trap <= 1'b0;
      cmt_cause   <= '0;
      endcode     <= '0;
      retire_cnt  <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (fire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
            // ebreak wins over a mispredict on the same instruction
            if (g_ebreak) begin
              state       <= S_TRAP;
              commit_trap <= 1'b1;
              cmt_cause   <= XLEN'(3);
              endcode     <= g_a0;
            end else if (g_mis) begin
              state     <= S_FLUSH;
              flush_req <= 1'b1;
              flush_pc  <= g_target;
            end
          end
        end
        S_FLUSH: begin
          if (cmt.flush_ack) begin
            flush_req <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_TRAP:  ;
        default: state <= S_RUN;
      endcase
    end
  end

  assign cmt.cmt_i_ready = ready;
  assign cmt.flush_req   = flush_req;
  assign cmt.flush_pc    = flush_pc;

endmodule

// File: tb/tb_exu_commit_mc.sv
// Directed-vector bench for exu_commit_mc; a second instance with a 4-bit
// retire counter covers counter wrap.
module tb_exu_commit_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  exu_commit_mc_if #(.NCH(2), .XLEN(32), .PC_W(32)) bus ();
  exu_commit_mc_if #(.NCH(2), .XLEN(32), .PC_W(32)) wbus ();

  logic        commit_trap, w_trap;
  logic [31:0] cmt_cause, endcode, w_cause, w_endcode;
  logic [63:0] retire_cnt;
  logic [3:0]  w_cnt;

  exu_commit_mc #(.NCH(2), .XLEN(32), .PC_W(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .cmt(bus),
    .commit_trap(commit_trap), .cmt_cause(cmt_cause),
    .endcode(endcode), .retire_cnt(retire_cnt)
  );

  exu_commit_mc #(.NCH(2), .XLEN(32), .PC_W(32), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .cmt(wbus),
    .commit_trap(w_trap), .cmt_cause(w_cause),
    .endcode(w_endcode), .retire_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.cmt_i_valid     = '0;
    bus.cmt_i_pc        = '0;
    bus.cmt_i_imm       = '0;
    bus.cmt_i_bjp       = '0;
    bus.cmt_i_bjp_taken = '0;
    bus.cmt_i_bjp_prdt  = '0;
    bus.cmt_i_ebreak    = '0;
    bus.cmt_i_a0        = '0;
    bus.flush_ack       = 1'b0;
  endtask

  task automatic drive(input int k, input logic [31:0] pc, input logic [31:0] imm,
                       input logic bjp, input logic taken, input logic prdt,
                       input logic ebreak, input logic [31:0] a0);
    bus.cmt_i_valid[k]       = 1'b1;
    bus.cmt_i_pc[k*32 +: 32]  = pc;
    bus.cmt_i_imm[k*32 +: 32] = imm;
    bus.cmt_i_bjp[k]         = bjp;
    bus.cmt_i_bjp_taken[k]   = taken;
    bus.cmt_i_bjp_prdt[k]    = prdt;
    bus.cmt_i_ebreak[k]      = ebreak;
    bus.cmt_i_a0[k*32 +: 32]  = a0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_flush_req"}, 64'(bus.flush_req), 64'd0);
    chk({tag, "_flush_pc"},  64'(bus.flush_pc), 64'd0);
    chk({tag, "_trap"},      64'(commit_trap), 64'd0);
    chk({tag, "_cause"},     64'(cmt_cause), 64'd0);
    chk({tag, "_endcode"},   64'(endcode), 64'd0);
    chk({tag, "_cnt"},       retire_cnt, 64'd0);
  endtask

  initial begin
    clear_in();
    wbus.cmt_i_valid = '0; wbus.cmt_i_pc = '0; wbus.cmt_i_imm = '0;
    wbus.cmt_i_bjp = '0; wbus.cmt_i_bjp_taken = '0; wbus.cmt_i_bjp_prdt = '0;
    wbus.cmt_i_ebreak = '0; wbus.cmt_i_a0 = '0; wbus.flush_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_idle_outputs("reset");
    chk("reset_ready", 64'(bus.cmt_i_ready), 64'd0);

    // fixed priority, channel 1 starved
    drive(0, 32'h1000, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h2000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("prio_ready", 64'(bus.cmt_i_ready), 64'b01);
      tick();
      chk("prio_cnt", retire_cnt, 64'(i + 1));
    end
    bus.cmt_i_valid[0] = 1'b0;
    #1 chk("ch1_ready", 64'(bus.cmt_i_ready), 64'b10);
    tick();
    chk("ch1_cnt", retire_cnt, 64'd4);
    clear_in();

    // mispredict taken, ack held off
    drive(0, 32'h8000_0010, 32'h20, 1, 1, 0, 0, 0);
    tick();
    clear_in();
    drive(1, 32'h3000, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mt_req", 64'(bus.flush_req), 64'd1);
    chk("mt_pc", 64'(bus.flush_pc), 64'h8000_0030);
    chk("mt_cnt", retire_cnt, 64'd5);
    chk("mt_ready", 64'(bus.cmt_i_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mt_hold_req", 64'(bus.flush_req), 64'd1);
      chk("mt_hold_pc", 64'(bus.flush_pc), 64'h8000_0030);
      chk("mt_hold_ready", 64'(bus.cmt_i_ready), 64'd0);
      chk("mt_hold_cnt", retire_cnt, 64'd5);
    end
    bus.flush_ack = 1'b1;
    tick();
    bus.flush_ack = 1'b0;
    #1;
    chk("mt_ack_req", 64'(bus.flush_req), 64'd0);
    chk("mt_regrant", 64'(bus.cmt_i_ready), 64'b10);
    tick();
    chk("mt_regrant_cnt", retire_cnt, 64'd6);
    clear_in();
    bus.flush_ack = 1'b1;
    tick();
    chk("stray_ack_req", 64'(bus.flush_req), 64'd0);
    chk("stray_ack_cnt", retire_cnt, 64'd6);
    clear_in();

    // mispredict not taken, then correct prediction
    drive(0, 32'h8000_0100, 32'h40, 1, 0, 1, 0, 0);
    tick();
    clear_in();
    chk("mn_req", 64'(bus.flush_req), 64'd1);
    chk("mn_pc", 64'(bus.flush_pc), 64'h8000_0104);
    chk("mn_cnt", retire_cnt, 64'd7);
    bus.flush_ack = 1'b1;
    tick();
    bus.flush_ack = 1'b0;
    chk("mn_ack_req", 64'(bus.flush_req), 64'd0);
    drive(0, 32'h8000_0200, 32'h8, 1, 1, 1, 0, 0);
    tick();
    clear_in();
    chk("ok_pred_req", 64'(bus.flush_req), 64'd0);
    chk("ok_pred_cnt", retire_cnt, 64'd8);

    // ebreak on ch1 with ch0 idle
    drive(1, 32'h4000, 0, 0, 0, 0, 1, 32'd0);
    #1 chk("eb_ready", 64'(bus.cmt_i_ready), 64'b10);
    tick();
    clear_in();
    drive(0, 32'h5000, 0, 0, 0, 0, 0, 0);
    #1;
    chk("eb_trap", 64'(commit_trap), 64'd1);
    chk("eb_cause", 64'(cmt_cause), 64'd3);
    chk("eb_endcode", 64'(endcode), 64'd0);
    chk("eb_cnt", retire_cnt, 64'd9);
    chk("eb_ready_after", 64'(bus.cmt_i_ready), 64'd0);
    tick(); tick();
    chk("eb_sticky", 64'(commit_trap), 64'd1);
    chk("eb_frozen_cnt", retire_cnt, 64'd9);

    // reset while trapped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_in();
    chk_idle_outputs("rst_trap");

    // ebreak a0=1 on ch0 while ch1 carries a different a0
    drive(0, 32'h6000, 0, 0, 0, 0, 1, 32'd1);
    drive(1, 32'h6004, 0, 0, 0, 0, 1, 32'h55);
    tick();
    clear_in();
    chk("eb1_trap", 64'(commit_trap), 64'd1);
    chk("eb1_endcode", 64'(endcode), 64'd1);
    chk("eb1_cnt", retire_cnt, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // ebreak with mispredict set on the same instruction
    drive(0, 32'h7000, 32'h100, 1, 1, 0, 1, 32'h7);
    tick();
    clear_in();
    chk("ebmis_trap", 64'(commit_trap), 64'd1);
    chk("ebmis_req", 64'(bus.flush_req), 64'd0);
    chk("ebmis_endcode", 64'(endcode), 64'd7);
    tick();
    chk("ebmis_req_held", 64'(bus.flush_req), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // reset while flushing
    drive(0, 32'h8000_0000, 32'h10, 1, 1, 0, 0, 0);
    tick();
    clear_in();
    chk("rf_req_before", 64'(bus.flush_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("rst_flush");
    drive(0, 32'h9000, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_flush_run", 64'(bus.cmt_i_ready), 64'b01);
    clear_in();

    // wrap of a 4-bit counter
    wbus.cmt_i_valid = 2'b01;
    repeat (15) tick();
    chk("wrap_15", 64'(w_cnt), 64'd15);
    tick();
    chk("wrap_0", 64'(w_cnt), 64'd0);
    wbus.cmt_i_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/exu_commit_mc.md
Name: exu_commit_mc

Overview:
Multi-channel commit stage for the NPC execute unit. It accepts retiring instructions from NCH execution channels (ALU, LSU, CSR, ...) and commits at most one per cycle using fixed priority. It resolves branch mispredictions into a registered flush/redirect handshake toward IFU, and captures ebreak as a sticky trap carrying cause and exit code. It also keeps a retired-instruction counter. It sits between the per-channel execute outputs and the IFU redirect / simulation-trap logic.

Parameters:
NCH, 2, number of commit channels; index 0 has highest priority
XLEN, 32, data width of imm, a0, cmt_cause and endcode
PC_W, 32, program counter width
CNT_W, 64, width of the retire counter

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
cmt_i_valid  input  NCH  per-channel commit request
cmt_i_ready  output  NCH  per-channel accept; at most one bit set
cmt_i_pc  input  NCH*PC_W  channel k occupies bits [k*PC_W +: PC_W]
cmt_i_imm  input  NCH*XLEN  branch offset, packed the same way
cmt_i_bjp  input  NCH  instruction is a branch or jump
cmt_i_bjp_taken  input  NCH  resolved direction
cmt_i_bjp_prdt  input  NCH  predicted direction
cmt_i_ebreak  input  NCH  instruction is ebreak
cmt_i_a0  input  NCH*XLEN  value of register a0 at commit
flush_req  output  1  redirect request to IFU
flush_ack  input  1  IFU accepts the redirect
flush_pc  output  PC_W  redirect target
commit_trap  output  1  sticky trap indicator
cmt_cause  output  XLEN  trap cause
endcode  output  XLEN  a0 captured at ebreak
retire_cnt  output  CNT_W  count of committed instructions

Behaviour:
- State machine has three states: RUN, FLUSH, TRAP. On rst the state is RUN and every output is 0.
- Grant in RUN: g = the lowest index k with cmt_i_valid[k]=1. cmt_i_ready = onehot(g). If no channel is valid, ready is all zero.
  - ready is combinational from valid and state. It does not depend on flush_ack.
- Fire: a commit happens when valid[g] & ready[g]. Exactly one commit can happen per cycle. retire_cnt increments by 1 on each fire and wraps modulo 2^CNT_W.
- Mispredict: mis = bjp[g] & (bjp_taken[g] != bjp_prdt[g]).
  - On a fire with mis=1, the next cycle has flush_req=1 and the state is FLUSH.
  - flush_pc = taken ? pc+imm : pc+4, computed modulo 2^PC_W with imm truncated to PC_W.
- FLUSH:
  - cmt_i_ready is all zero; channel inputs are ignored.
  - flush_req and flush_pc stay stable until flush_ack=1 is sampled.
  - On that edge, flush_req drops to 0 and the state returns to RUN. The first new grant is possible in the following cycle.
  - flush_ack while flush_req=0 is ignored.
- Ebreak: on a fire with ebreak[g]=1 the state becomes TRAP.
  - Next cycle: commit_trap=1, cmt_cause=3 (breakpoint), endcode=a0[g].
  - ebreak takes priority over mis; no flush is raised.
- TRAP:
  - Sticky until rst; cmt_i_ready is all zero.
  - retire_cnt, endcode and cmt_cause are frozen.
  - A trap while flush_req is pending is impossible, because FLUSH blocks all commits.
- Non-granted valid channels are not consumed. They must hold their payload (valid/ready rule); the block never drops a request.
- Reset mid-operation:
  - rst in FLUSH clears flush_req immediately at the edge.
  - rst in TRAP clears commit_trap, cmt_cause, endcode and retire_cnt.
- Latency: one cycle from fire to flush_req or commit_trap.
- Throughput: one commit per cycle in RUN with no bubbles.

Test Plan:
1. Fixed priority: NCH=2, valid=2'b11 with non-branches for 3 cycles. Expect ready=2'b01 each cycle and channel 1 starved; retire_cnt goes 0→3. Then drop valid[0]: expect ready=2'b10 and retire_cnt=4.
2. Mispredict taken: ch0 pc=0x80000010, imm=0x20, bjp=1, taken=1, prdt=0. Expect next cycle flush_req=1 and flush_pc=0x80000030. Hold flush_ack=0 for 3 cycles: expect ready=0 and flush_pc stable. Pulse ack: expect flush_req=0, then a grant in the next cycle.
3. Mispredict not-taken: pc=0x80000100, taken=0, prdt=1. Expect flush_pc=0x80000104. Correct prediction with taken=prdt=1: expect no flush_req and retire_cnt+1.
4. Ebreak: ch1 ebreak=1, a0=0 with ch0 idle. Expect next cycle commit_trap=1, cmt_cause=3, endcode=0, and ready=0 thereafter. Later valid ebreak with a0=1 after rst: expect endcode=1.
5. Ebreak with bjp and mispredict set on the same instruction: expect trap only and flush_req held at 0.
6. Reset: assert rst while in FLUSH, and separately while in TRAP. Expect all outputs 0 on the next cycle and the state back in RUN. Wrap check with CNT_W=4: 16 fires → retire_cnt=0.
